// File: rtl/overlay_sequencer.sv
// Stage banner / score overlay sequencer: frame-synchronous enables for the text draw requests.
// Build option: define OVERLAY_BLINK_EN to include the blinking phase ahead of the steady hold.
module overlay_sequencer #(
  parameter logic [7:0] BANNER_FRAMES      = 8'd120,
  parameter logic [7:0] BLINK_FRAMES       = 8'd60,
  parameter logic [7:0] BLINK_HALF         = 8'd8,
  parameter logic [7:0] SCORE_FLASH_FRAMES = 8'd30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       stageReq,
  input  logic [3:0] newStage,
  input  logic       skip,
  input  logic       scoreEvt,
  output logic       stageShowEn,
  output logic       scoreShowEn,
  output logic       scoreHighlight,
  output logic [3:0] stageNum,
  output logic       stageAck,
  output logic       bannerBusy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, BLINK = 2'd2, HOLD = 2'd3} state_t;

  state_t     state_reg, state_next;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic [7:0] flash_cnt_reg, flash_cnt_next;
  logic       abort_reg, abort_next;
  logic       flash_pend_reg, flash_pend_next;
  logic [3:0] stage_num_reg, stage_num_next;
  logic       ack_next;
  logic       stage_show_next, score_show_next, busy_next, highlight_next;

`ifdef OVERLAY_BLINK_EN
  logic       phase_reg, phase_next;
  logic [7:0] half_cnt_reg, half_cnt_next;
`else
  // Blink timing parameters stay in the parameter list so both builds share one instantiation.
  logic unused_blink_params;
  assign unused_blink_params = (BLINK_FRAMES == BLINK_HALF);
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      frame_cnt_reg  <= 8'd0;
      flash_cnt_reg  <= 8'd0;
      abort_reg      <= 1'b0;
      flash_pend_reg <= 1'b0;
      stage_num_reg  <= 4'd0;
      stageAck       <= 1'b0;
      stageShowEn    <= 1'b0;
      scoreShowEn    <= 1'b0;
      scoreHighlight <= 1'b0;
      bannerBusy     <= 1'b0;
`ifdef OVERLAY_BLINK_EN
      phase_reg      <= 1'b0;
      half_cnt_reg   <= 8'd0;
`endif
    end else begin
      state_reg      <= state_next;
      frame_cnt_reg  <= frame_cnt_next;
      flash_cnt_reg  <= flash_cnt_next;
      abort_reg      <= abort_next;
      flash_pend_reg <= flash_pend_next;
      stage_num_reg  <= stage_num_next;
      stageAck       <= ack_next;
      stageShowEn    <= stage_show_next;
      scoreShowEn    <= score_show_next;
      scoreHighlight <= highlight_next;
      bannerBusy     <= busy_next;
`ifdef OVERLAY_BLINK_EN
      phase_reg      <= phase_next;
      half_cnt_reg   <= half_cnt_next;
`endif
    end
  end

  assign stageNum = stage_num_reg;

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    abort_next     = abort_reg;
    stage_num_next = stage_num_reg;
    ack_next       = 1'b0;
`ifdef OVERLAY_BLINK_EN
    phase_next     = phase_reg;
    half_cnt_next  = half_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (stageReq) begin
          stage_num_next = newStage;
          ack_next       = 1'b1;
          state_next     = ARMED;
        end
      end
      ARMED: begin
        if (startOfFrame) begin
`ifdef OVERLAY_BLINK_EN
          frame_cnt_next = BLINK_FRAMES - 8'd1;
          phase_next     = 1'b1;
          half_cnt_next  = BLINK_HALF - 8'd1;
          state_next     = BLINK;
`else
          frame_cnt_next = BANNER_FRAMES - 8'd1;
          state_next     = HOLD;
`endif
        end
      end
`ifdef OVERLAY_BLINK_EN
      BLINK: begin
        if (skip) abort_next = 1'b1;
        if (startOfFrame) begin
          if (abort_reg || skip) begin
            state_next = IDLE;
          end else if (frame_cnt_reg == 8'd0) begin
            frame_cnt_next = BANNER_FRAMES - 8'd1;
            state_next     = HOLD;
          end else begin
            frame_cnt_next = frame_cnt_reg - 8'd1;
            // Phase flips once the half-period sub-counter has run out.
            if (half_cnt_reg == 8'd0) begin
              phase_next    = ~phase_reg;
              half_cnt_next = BLINK_HALF - 8'd1;
            end else begin
              half_cnt_next = half_cnt_reg - 8'd1;
            end
          end
        end
      end
`endif
      HOLD: begin
        if (skip) abort_next = 1'b1;
        if (startOfFrame) begin
          if (abort_reg || skip || frame_cnt_reg == 8'd0) begin
            state_next = IDLE;
          end else begin
            frame_cnt_next = frame_cnt_reg - 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // A pending abort never outlives the banner it was raised against.
    if (state_next == IDLE) abort_next = 1'b0;
  end

  always_comb begin
    flash_cnt_next  = flash_cnt_reg;
    flash_pend_next = flash_pend_reg;
    if (startOfFrame) begin
      if (scoreEvt || flash_pend_reg) begin
        flash_cnt_next  = SCORE_FLASH_FRAMES;
        flash_pend_next = 1'b0;
      end else if (flash_cnt_reg != 8'd0) begin
        flash_cnt_next = flash_cnt_reg - 8'd1;
      end
    end else if (scoreEvt) begin
      flash_pend_next = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they move on the triggering edge.
  always_comb begin
`ifdef OVERLAY_BLINK_EN
    stage_show_next = (state_next == HOLD) || ((state_next == BLINK) && phase_next);
`else
    stage_show_next = (state_next == HOLD);
`endif
    score_show_next = !((state_next == BLINK) || (state_next == HOLD));
    busy_next       = (state_next != IDLE);
    highlight_next  = (flash_cnt_next != 8'd0);
  end

endmodule

// File: tb/tb_overlay_sequencer.sv
// Scoreboard bench for overlay_sequencer: per-frame expectations are queued with the stimulus.
// Works for both builds (OVERLAY_BLINK_EN defined or not).
module tb_overlay_sequencer;

  localparam logic [7:0] P_BANNER = 8'd3;
  localparam logic [7:0] P_BLINK  = 8'd4;
  localparam logic [7:0] P_HALF   = 8'd2;
  localparam logic [7:0] P_FLASH  = 8'd3;
`ifdef OVERLAY_BLINK_EN
  localparam int NF        = 7;
  localparam int HOLD_IDX  = 4;
`else
  localparam int NF        = 3;
  localparam int HOLD_IDX  = 0;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       stageReq = 1'b0;
  logic [3:0] newStage = 4'd0;
  logic       skip = 1'b0;
  logic       scoreEvt = 1'b0;
  logic       stageShowEn, scoreShowEn, scoreHighlight, stageAck, bannerBusy;
  logic [3:0] stageNum;

  overlay_sequencer #(
    .BANNER_FRAMES(P_BANNER), .BLINK_FRAMES(P_BLINK),
    .BLINK_HALF(P_HALF), .SCORE_FLASH_FRAMES(P_FLASH)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .stageReq(stageReq),
    .newStage(newStage), .skip(skip), .scoreEvt(scoreEvt),
    .stageShowEn(stageShowEn), .scoreShowEn(scoreShowEn), .scoreHighlight(scoreHighlight),
    .stageNum(stageNum), .stageAck(stageAck), .bannerBusy(bannerBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit stage_show;
    bit score_show;
    bit busy;
  } banner_exp_t;

  banner_exp_t bq[$];
  bit          hq[$];
  int          flash_model = 0;
  bit          pend_model  = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          frame_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected stageShowEn for banner frame i (0 = first visible frame).
  function automatic bit exp_show(input int i);
`ifdef OVERLAY_BLINK_EN
    if (i < int'(P_BLINK)) return ((i / int'(P_HALF)) % 2) == 0;
`endif
    return (i < NF);
  endfunction

  task automatic push_banner(input int frames);
    banner_exp_t e;
    for (int i = 0; i < frames; i++) begin
      e.stage_show = exp_show(i);
      e.score_show = 1'b0;
      e.busy       = 1'b1;
      bq.push_back(e);
    end
    e.stage_show = 1'b0;
    e.score_show = 1'b1;
    e.busy       = 1'b0;
    bq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_frame(input bit evt);
    banner_exp_t e;
    bit          h;
    if (evt || pend_model) begin
      flash_model = int'(P_FLASH);
      pend_model  = 1'b0;
    end else if (flash_model > 0) begin
      flash_model--;
    end
    hq.push_back(flash_model != 0);
    startOfFrame = 1'b1;
    scoreEvt     = evt;
    tick(1);
    startOfFrame = 1'b0;
    scoreEvt     = 1'b0;
    frame_no++;
    if (bq.size() > 0) begin
      e = bq.pop_front();
    end else begin
      e.stage_show = 1'b0;
      e.score_show = 1'b1;
      e.busy       = 1'b0;
    end
    h = hq.pop_front();
    check($sformatf("frame%0d stageShowEn", frame_no), stageShowEn, e.stage_show);
    check($sformatf("frame%0d scoreShowEn", frame_no), scoreShowEn, e.score_show);
    check($sformatf("frame%0d bannerBusy", frame_no), bannerBusy, e.busy);
    check($sformatf("frame%0d scoreHighlight", frame_no), scoreHighlight, h);
    check($sformatf("frame%0d stageAck", frame_no), stageAck, 1'b0);
  endtask

  task automatic run_frames(input int n);
    for (int k = 0; k < n; k++) begin
      do_frame(1'b0);
      if (k < n - 1) tick(4);
    end
  endtask

  task automatic expect_accept(input logic [3:0] num);
    check("ack pulse", stageAck, 1'b1);
    check("ack stageNum", stageNum, num);
    check("ack bannerBusy", bannerBusy, 1'b1);
    check("armed stageShowEn", stageShowEn, 1'b0);
    check("armed scoreShowEn", scoreShowEn, 1'b1);
  endtask

  task automatic check_reset_values(input string tag, input bit score_show);
    check({tag, " stageShowEn"}, stageShowEn, 1'b0);
    check({tag, " scoreShowEn"}, scoreShowEn, score_show);
    check({tag, " scoreHighlight"}, scoreHighlight, 1'b0);
    check({tag, " stageNum"}, stageNum, 4'd0);
    check({tag, " stageAck"}, stageAck, 1'b0);
    check({tag, " bannerBusy"}, bannerBusy, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and release.
    tick(2);
    check_reset_values("in reset", 1'b0);
    resetN = 1'b1;
    tick(1);
    check_reset_values("after release", 1'b1);
    tick(3);

    // Single banner, request dropped after the ack.
    stageReq = 1'b1; newStage = 4'd4;
    tick(1);
    expect_accept(4'd4);
    stageReq = 1'b0;
    push_banner(NF);
    tick(1);
    check("ack single-cycle", stageAck, 1'b0);
    tick(3);
    run_frames(NF + 1);
    tick(4);

    // Request held through a full banner: re-accepted one cycle after IDLE.
    stageReq = 1'b1; newStage = 4'd9;
    tick(1);
    expect_accept(4'd9);
    newStage = 4'd11;
    push_banner(NF);
    tick(4);
    run_frames(NF + 1);
    tick(1);
    expect_accept(4'd11);
    stageReq = 1'b0;
    push_banner(NF);
    tick(4);
    run_frames(NF + 1);
    tick(4);

    // Skip while idle and while armed is ignored; skip in HOLD aborts at the next frame.
    skip = 1'b1; tick(1); skip = 1'b0;
    check("skip idle busy", bannerBusy, 1'b0);
    stageReq = 1'b1; newStage = 4'd5;
    tick(1);
    expect_accept(4'd5);
    stageReq = 1'b0;
    skip = 1'b1; tick(1); skip = 1'b0;
    check("skip armed busy", bannerBusy, 1'b1);
    push_banner(HOLD_IDX + 1);
    tick(3);
    run_frames(HOLD_IDX + 1);
    tick(2);
    skip = 1'b1; tick(1); skip = 1'b0;
    tick(1);
    check("skip pending busy", bannerBusy, 1'b1);
    check("skip pending stageShowEn", stageShowEn, 1'b1);
    do_frame(1'b0);
    tick(4);

    // Score flash: event on a frame edge, then a mid-frame retrigger.
    do_frame(1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(4);
      do_frame(1'b0);
    end
    tick(4);
    do_frame(1'b1);
    tick(4);
    do_frame(1'b0);
    tick(1);
    scoreEvt = 1'b1; tick(1); scoreEvt = 1'b0;
    pend_model = 1'b1;
    check("mid-frame evt no early load", scoreHighlight, flash_model != 0);
    tick(2);
    for (int k = 0; k < 4; k++) begin
      do_frame(1'b0);
      tick(4);
    end

    // Asynchronous reset in the middle of a banner with a request still held.
    stageReq = 1'b1; newStage = 4'd7;
    tick(1);
    expect_accept(4'd7);
    push_banner(NF);
    tick(4);
    do_frame(1'b1);
    tick(4);
    do_frame(1'b0);
    tick(2);
    #2 resetN = 1'b0;
    #1;
    check_reset_values("async reset", 1'b0);
    bq.delete();
    hq.delete();
    flash_model = 0;
    pend_model  = 1'b0;
    tick(2);
    stageReq = 1'b0;
    resetN = 1'b1;
    tick(1);
    check_reset_values("re-release", 1'b1);
    tick(3);
    do_frame(1'b0);
    tick(4);
    do_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/overlay_sequencer.md
# overlay_sequencer

Frame-synchronous controller that schedules the text overlays composited onto the playfield background. It accepts stage-change requests through a req/ack handshake and runs a stage banner sequence: blink, then hold, then release. While the banner is up it suppresses the score overlay. It also drives a timed highlight after each score event. It sits between game logic and the background drawer; its enables gate the stage and score draw requests before the background mux. All visible changes occur only on frame boundaries.

## Interface
- BANNER_FRAMES, 120: frames the banner is held steady after blinking (1..255).
- BLINK_FRAMES, 60: frames of blinking before hold (1..255).
- BLINK_HALF, 8: frames per blink half-period (1..255).
- SCORE_FLASH_FRAMES, 30: frames scoreHighlight stays high after a score event (1..255).
- clk  in  1  pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per frame.
- stageReq  in  1  level request for a stage banner; held until stageAck.
- newStage  in  4  stage number; valid while stageReq is high.
- skip  in  1  one-cycle pulse that aborts an active banner.
- scoreEvt  in  1  one-cycle pulse on a score change.
- stageShowEn  out  1  gates the stage text draw request.
- scoreShowEn  out  1  gates the score text draw request.
- scoreHighlight  out  1  score flash indication.
- stageNum  out  4  latched stage number for the text generator.
- stageAck  out  1  one-cycle accept pulse.
- bannerBusy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ARMED, BLINK, HOLD. One 8-bit frame counter frameCnt, one 8-bit flashCnt, one blink phase bit.
- IDLE: if stageReq=1, latch newStage into stageNum, pulse stageAck, go to ARMED. stageReq is ignored in every other state, and no ack is given there. The requester keeps req high, so the request is effectively queued.
- ARMED: at the next startOfFrame, load frameCnt=BLINK_FRAMES-1, set phase=1, go to BLINK.
- BLINK: on each startOfFrame, decrement frameCnt. Phase toggles every BLINK_HALF frames, tracked by a sub-counter. When frameCnt=0 at a startOfFrame, load BANNER_FRAMES-1 and go to HOLD.
- HOLD: decrement frameCnt on each startOfFrame. At frameCnt=0 with startOfFrame, go to IDLE.
- skip in BLINK or HOLD sets an abort flag. The next startOfFrame goes to IDLE, and that frame's counter action is discarded. skip in IDLE or ARMED is ignored.
- stageShowEn = (BLINK and phase) or HOLD.
- scoreShowEn = not (BLINK or HOLD).
- scoreEvt: flashCnt is loaded with SCORE_FLASH_FRAMES at the first startOfFrame at or after the event. If the event coincides with a startOfFrame, the load happens in that same cycle. After loading, flashCnt decrements on each later startOfFrame down to 0. A new event reloads it (retrigger).
- scoreHighlight = (flashCnt != 0). It runs independently of the banner FSM.

## Timing
- All outputs are registered.
- Reset values: stageShowEn=0, scoreShowEn=0, scoreHighlight=0, stageNum=0, stageAck=0, bannerBusy=0, state=IDLE, all counters 0, abort=0.
- scoreShowEn rises on the first clk edge after reset release.
- stageAck is high exactly one cycle: the cycle after the first edge that samples stageReq=1 in IDLE. stageNum is valid in that same cycle.
- Outputs change one cycle after the startOfFrame edge that triggers them.
- Banner length from the first visible frame: BLINK_FRAMES + BANNER_FRAMES frames.
- A stageReq held high through the return to IDLE is accepted 1 cycle after IDLE is re-entered.
- Reset asserted mid-sequence returns immediately to the reset values; any pending request or abort is lost.

## Configuration
- OVERLAY_BLINK_EN defined: the BLINK state and blink phase logic are present, as described above.
- OVERLAY_BLINK_EN undefined: ARMED goes directly to HOLD, loading BANNER_FRAMES-1. stageShowEn is steady high for BANNER_FRAMES frames. BLINK_FRAMES and BLINK_HALF are unused.

## Test plan
- Reset release, stageReq=0 -> one cycle later: scoreShowEn=1, all other outputs 0, bannerBusy=0.
- stageReq=1, newStage=4, with BLINK_FRAMES=4, BLINK_HALF=2, BANNER_FRAMES=3 -> single stageAck, stageNum=4. Starting after the next startOfFrame, stageShowEn over 7 frames = 1,1,0,0,1,1,1. scoreShowEn=0 during those frames, then 1 again, and bannerBusy=0.
- stageReq held through a full banner -> second stageAck arrives 1 cycle after IDLE is re-entered, and a new sequence runs.
- skip during HOLD -> state is IDLE after the next startOfFrame; stageShowEn=0, scoreShowEn=1.
- scoreEvt coincident with startOfFrame, SCORE_FLASH_FRAMES=3 -> scoreHighlight high for 3 frames. A scoreEvt in the 2nd frame extends it to 3 frames counted from the reload.
- resetN low during BLINK -> all outputs at reset values immediately. With OVERLAY_BLINK_EN undefined, the first scenario's request instead gives stageShowEn steady high for 3 frames.
